// File: rtl/memory_dual_port.sv
// Simple dual-port RAM: one write port with byte lanes, one read port with 1- or 2-cycle
// latency, selectable read-during-write result, and a post-reset sweep that zeroes the array.
module memory_dual_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    read_enable,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    init_done,
  output logic                    dbg_state_o
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_fire;
  logic                    rd_fire;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    s1_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;

  // Traffic is only accepted once the sweep has finished and reset is released.
  assign wr_fire = reset && (state_q == ST_READY) && write_enable;
  assign rd_fire = reset && (state_q == ST_READY) && read_enable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET == 0) begin
          state_d = ST_READY;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == '1) state_d = ST_READY;
        end
      end
      default: ;
    endcase
  end

  // Merged word as it will look after this cycle's write; feeds write-first reads.
  always_comb begin
    wr_word = mem_q[write_addr];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = write_data[8*i +: 8];
    end
  end

  assign rd_word = ((RDW_MODE == 1) && wr_fire && (write_addr == read_addr))
                   ? wr_word : mem_q[read_addr];

  always_ff @(posedge clk) begin
    if (reset && (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0)) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byte_en[i]) mem_q[write_addr][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  // Data registers hold between reads; only the valid bits pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) s1_data_q <= rd_word;
      if (RD_LATENCY == 2) begin
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) rd_data_q <= s1_data_q;
      end else begin
        rd_valid_q <= rd_fire;
        if (rd_fire) rd_data_q <= rd_word;
      end
    end
  end

  assign read_data   = rd_data_q;
  assign read_valid  = rd_valid_q;
  assign init_done   = (state_q == ST_READY);
  assign dbg_state_o = state_q;

endmodule
